pipe_ctrl_unit: RTL and testbench

//  Pipelined successor to the single-cycle opcode decoder of the MIPS core.
//  - Decodes the ID-stage opcode into WB/M/EX control bundles.
//  - Carries the bundles through ID/EX, EX/MEM and MEM/WB control registers.
//  - Detects load-use hazards and inserts bubbles.
//  - Flushes wrong-path instructions when a BEQ resolves taken in MEM.
//  - Keeps a saturating stall/flush performance counter.

---
 rtl/pipe_ctrl_unit.sv | 146 ++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// +--------------------------------------------------------------------------+
// | pipe_ctrl_unit: pipelined MIPS control decode, load-use/branch hazards    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module pipe_ctrl_unit #(
  parameter int REG_W     = 5,
  parameter int ALUOP_W   = 3,
  parameter int HAZARD_EN = 1,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opc_id,
  input  logic [REG_W-1:0]   rs_id,
  input  logic [REG_W-1:0]   rt_id,
  input  logic               zero_mem,
  output logic [ALUOP_W+1:0] ex_ctrl,
  output logic [2:0]         m_ctrl,
  output logic [1:0]         wb_ctrl,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               if_flush,
  output logic               illegal_ex,
  output logic [CNT_W-1:0]   perf_stalls,
  output logic [CNT_W-1:0]   perf_flushes
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  logic               alu_src, reg_dst, mem_write, mem_read, branch, mem_to_reg, reg_write;
  logic [ALUOP_W-1:0] alu_op;
  logic               dec_ill;

  logic [ALUOP_W+1:0] idex_ex_q, idex_ex_d;
  logic [2:0]         idex_m_q, idex_m_d, exmem_m_q, exmem_m_d;
  logic [1:0]         idex_wb_q, idex_wb_d, exmem_wb_q, exmem_wb_d, memwb_wb_q, memwb_wb_d;
  logic [REG_W-1:0]   idex_rt_q, idex_rt_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   stalls_q, stalls_d, flushes_q, flushes_d;
  logic               taken, hazard, stall;

  always_comb begin
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    branch     = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_op     = '0;
    dec_ill    = 1'b0;
    case (opc_id)
      OP_R:    begin reg_dst = 1'b1; alu_op = ALUOP_W'(3'b010); mem_to_reg = 1'b1; reg_write = 1'b1; end
      OP_LW:   begin alu_src = 1'b1; mem_read = 1'b1; reg_write = 1'b1; end
      OP_SW:   begin alu_src = 1'b1; mem_write = 1'b1; end
      OP_BEQ:  begin alu_op = ALUOP_W'(3'b001); branch = 1'b1; end
      OP_ADDI: begin alu_src = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; end
      OP_SLTI: begin alu_op = ALUOP_W'(3'b100); alu_src = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; end
      OP_ANDI: begin alu_op = ALUOP_W'(3'b101); alu_src = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; end
      OP_ORI:  begin alu_op = ALUOP_W'(3'b111); alu_src = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; end
      default: dec_ill = 1'b1;
    endcase
  end

  // A taken branch squashes the load-use stall: the dependent instruction is wrong-path anyway.
  assign taken  = exmem_m_q[0] & zero_mem;
  assign hazard = (HAZARD_EN != 0) & idex_m_q[1] & (idex_rt_q != '0) &
                  ((idex_rt_q == rs_id) | (idex_rt_q == rt_id));
  assign stall  = hazard & ~taken;

  always_comb begin
    idex_ex_d  = {alu_src, alu_op, reg_dst};
    idex_m_d   = {mem_write, mem_read, branch};
    idex_wb_d  = {mem_to_reg, reg_write};
    idex_rt_d  = rt_id;
    illegal_d  = dec_ill;
    exmem_m_d  = idex_m_q;
    exmem_wb_d = idex_wb_q;
    memwb_wb_d = exmem_wb_q;
    stalls_d   = stalls_q;
    flushes_d  = flushes_q;
    if (taken || stall) begin
      idex_ex_d = '0;
      idex_m_d  = '0;
      idex_wb_d = '0;
      idex_rt_d = '0;
      illegal_d = 1'b0;
    end
    if (taken) begin
      exmem_m_d  = '0;
      exmem_wb_d = '0;
    end
    if (stall && (stalls_q != '1))
      stalls_d = stalls_q + 1'b1;
    if (taken && (flushes_q != '1))
      flushes_d = flushes_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_ex_q  <= '0;
      idex_m_q   <= '0;
      idex_wb_q  <= '0;
      idex_rt_q  <= '0;
      illegal_q  <= 1'b0;
      exmem_m_q  <= '0;
      exmem_wb_q <= '0;
      memwb_wb_q <= '0;
      stalls_q   <= '0;
      flushes_q  <= '0;
    end else begin
      idex_ex_q  <= idex_ex_d;
      idex_m_q   <= idex_m_d;
      idex_wb_q  <= idex_wb_d;
      idex_rt_q  <= idex_rt_d;
      illegal_q  <= illegal_d;
      exmem_m_q  <= exmem_m_d;
      exmem_wb_q <= exmem_wb_d;
      memwb_wb_q <= memwb_wb_d;
      stalls_q   <= stalls_d;
      flushes_q  <= flushes_d;
    end
  end

  assign ex_ctrl      = idex_ex_q;
  assign m_ctrl       = exmem_m_q;
  assign wb_ctrl      = memwb_wb_q;
  assign illegal_ex   = illegal_q;
  assign pc_write     = ~stall;
  assign ifid_write   = ~stall;
  assign if_flush     = taken;
  assign perf_stalls  = stalls_q;
  assign perf_flushes = flushes_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
// +--------------------------------------------------------------------------+
// | tb_pipe_ctrl_unit: instruction-level model of the control pipeline        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pipe_ctrl_unit;

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] SLTI = 6'b001010;
  localparam logic [5:0] ORI  = 6'b001101;
  localparam logic [5:0] BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opc_id;
  logic [4:0] rs_id, rt_id;
  logic       zero_mem;

  logic [4:0]  ex_ctrl;
  logic [2:0]  m_ctrl;
  logic [1:0]  wb_ctrl;
  logic        pc_write, ifid_write, if_flush, illegal_ex;
  logic [15:0] perf_stalls, perf_flushes;

  logic [4:0]  ex_ctrl2;
  logic [2:0]  m_ctrl2;
  logic [1:0]  wb_ctrl2;
  logic        pc_write2, ifid_write2, if_flush2, illegal_ex2;
  logic [1:0]  perf_stalls2, perf_flushes2;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl_unit dut (
    .clk(clk), .rst_n(rst_n), .opc_id(opc_id), .rs_id(rs_id), .rt_id(rt_id),
    .zero_mem(zero_mem), .ex_ctrl(ex_ctrl), .m_ctrl(m_ctrl), .wb_ctrl(wb_ctrl),
    .pc_write(pc_write), .ifid_write(ifid_write), .if_flush(if_flush),
    .illegal_ex(illegal_ex), .perf_stalls(perf_stalls), .perf_flushes(perf_flushes)
  );

  pipe_ctrl_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .opc_id(opc_id), .rs_id(rs_id), .rt_id(rt_id),
    .zero_mem(zero_mem), .ex_ctrl(ex_ctrl2), .m_ctrl(m_ctrl2), .wb_ctrl(wb_ctrl2),
    .pc_write(pc_write2), .ifid_write(ifid_write2), .if_flush(if_flush2),
    .illegal_ex(illegal_ex2), .perf_stalls(perf_stalls2), .perf_flushes(perf_flushes2)
  );

  typedef struct packed {
    logic [4:0] ex;
    logic [2:0] m;
    logic [1:0] wb;
    logic       ill;
  } dec_t;

  typedef struct packed {
    logic [5:0] opc;
    logic [4:0] rt;
    logic       valid;
  } instr_t;

  // Control bundles straight from the opcode table: ex={ALUSrc,ALUOp,RegDst}, m={MW,MR,Br}, wb={M2R,RW}.
  function automatic dec_t decode(input logic [5:0] opc);
    case (opc)
      R:       return '{5'b0_010_1, 3'b000, 2'b11, 1'b0};
      LW:      return '{5'b1_000_0, 3'b010, 2'b01, 1'b0};
      SW:      return '{5'b1_000_0, 3'b100, 2'b00, 1'b0};
      BEQ:     return '{5'b0_001_0, 3'b001, 2'b00, 1'b0};
      ADDI:    return '{5'b1_000_0, 3'b000, 2'b11, 1'b0};
      SLTI:    return '{5'b1_100_0, 3'b000, 2'b11, 1'b0};
      6'b001100: return '{5'b1_101_0, 3'b000, 2'b11, 1'b0};
      ORI:     return '{5'b1_111_0, 3'b000, 2'b11, 1'b0};
      default: return '{5'b0, 3'b0, 2'b0, 1'b1};
    endcase
  endfunction

  instr_t s_ex, s_mem, s_wb;
  int     n_stalls, n_flushes;

  initial begin
    s_ex = '0; s_mem = '0; s_wb = '0; n_stalls = 0; n_flushes = 0;
  end

  function automatic bit m_taken();
    return s_mem.valid && s_mem.opc == BEQ && zero_mem;
  endfunction

  function automatic bit m_stall();
    return s_ex.valid && s_ex.opc == LW && s_ex.rt != 0 &&
           (s_ex.rt == rs_id || s_ex.rt == rt_id) && !m_taken();
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      s_ex <= '0; s_mem <= '0; s_wb <= '0; n_stalls <= 0; n_flushes <= 0;
    end else begin
      s_wb <= s_mem;
      if (m_taken()) begin
        s_mem <= '0;
        s_ex  <= '0;
        n_flushes <= n_flushes + 1;
      end else if (m_stall()) begin
        s_mem <= s_ex;
        s_ex  <= '0;
        n_stalls <= n_stalls + 1;
      end else begin
        s_mem <= s_ex;
        s_ex  <= '{opc_id, rt_id, 1'b1};
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("ex_ctrl",  32'(ex_ctrl),  32'(s_ex.valid  ? decode(s_ex.opc).ex  : 5'b0));
      chk("m_ctrl",   32'(m_ctrl),   32'(s_mem.valid ? decode(s_mem.opc).m  : 3'b0));
      chk("wb_ctrl",  32'(wb_ctrl),  32'(s_wb.valid  ? decode(s_wb.opc).wb  : 2'b0));
      chk("illegal_ex", 32'(illegal_ex), 32'(s_ex.valid & decode(s_ex.opc).ill));
      chk("pc_write",   32'(pc_write),   32'(!m_stall()));
      chk("ifid_write", 32'(ifid_write), 32'(!m_stall()));
      chk("if_flush",   32'(if_flush),   32'(m_taken()));
      chk("perf_stalls",   32'(perf_stalls),   32'(sat(n_stalls, 65535)));
      chk("perf_flushes",  32'(perf_flushes),  32'(sat(n_flushes, 65535)));
      chk("perf_stalls2",  32'(perf_stalls2),  32'(sat(n_stalls, 3)));
      chk("perf_flushes2", 32'(perf_flushes2), 32'(sat(n_flushes, 3)));
    end
  end

  task automatic cyc(input logic [5:0] o, input logic [4:0] rs, input logic [4:0] rt,
                     input logic z = 1'b0, input logic rn = 1'b1);
    @(negedge clk);
    opc_id = o; rs_id = rs; rt_id = rt; zero_mem = z; rst_n = rn;
    #3;
  endtask

  int saved;

  initial begin
    rst_n = 1'b0; opc_id = LW; rs_id = 5'd5; rt_id = 5'd5; zero_mem = 1'b0;
    @(posedge clk); #1 chk_en = 1'b1;
    cyc(LW, 5, 5, 0, 0);
    cyc(LW, 5, 5, 0, 0);
    cyc(R, 1, 2);
    chk("rst ex_ctrl", 32'(ex_ctrl), 0);
    chk("rst m_ctrl", 32'(m_ctrl), 0);
    chk("rst wb_ctrl", 32'(wb_ctrl), 0);
    chk("rst pc_write", 32'(pc_write), 1);
    chk("rst perf_stalls", 32'(perf_stalls), 0);

    cyc(LW, 1, 3);
    chk("R ex_ctrl", 32'(ex_ctrl), 32'(5'b0_010_1));
    cyc(SW, 4, 6);
    chk("LW ex_ctrl", 32'(ex_ctrl), 32'(5'b1_000_0));
    cyc(BEQ, 7, 8);
    chk("LW m_ctrl", 32'(m_ctrl), 32'(3'b010));
    cyc(ADDI, 9, 10);
    chk("BEQ ex_ctrl", 32'(ex_ctrl), 32'(5'b0_001_0));
    chk("LW wb_ctrl", 32'(wb_ctrl), 32'(2'b01));
    cyc(SLTI, 0, 0);
    chk("ADDI ex_ctrl", 32'(ex_ctrl), 32'(5'b1_000_0));
    cyc(ORI, 0, 0);
    chk("SLTI ex_ctrl", 32'(ex_ctrl), 32'(5'b1_100_0));
    cyc(R, 0, 0);
    cyc(R, 0, 0);

    // load-use stall
    cyc(LW, 0, 5);
    cyc(R, 5, 6);
    chk("stall pc_write", 32'(pc_write), 0);
    chk("stall ifid_write", 32'(ifid_write), 0);
    cyc(R, 5, 6);
    chk("bubble ex_ctrl", 32'(ex_ctrl), 0);
    chk("perf_stalls 1", 32'(perf_stalls), 1);
    cyc(LW, 0, 0);
    cyc(R, 0, 0);
    chk("rt0 pc_write", 32'(pc_write), 1);

    // taken branch
    cyc(BEQ, 1, 2);
    cyc(R, 0, 0);
    cyc(ADDI, 3, 4, 1);
    chk("taken if_flush", 32'(if_flush), 1);
    cyc(R, 0, 0);
    chk("flush ex_ctrl", 32'(ex_ctrl), 0);
    chk("flush m_ctrl", 32'(m_ctrl), 0);
    chk("perf_flushes 1", 32'(perf_flushes), 1);
    cyc(BEQ, 1, 2);
    cyc(R, 0, 0);
    cyc(ADDI, 3, 4, 0);
    chk("not taken if_flush", 32'(if_flush), 0);
    cyc(R, 0, 0, 1);
    cyc(R, 0, 0);

    // stall coincident with taken branch
    saved = int'(perf_stalls);
    cyc(BEQ, 1, 2);
    cyc(LW, 0, 5);
    cyc(R, 5, 5, 1);
    chk("coinc pc_write", 32'(pc_write), 1);
    chk("coinc if_flush", 32'(if_flush), 1);
    cyc(R, 0, 0);
    chk("coinc perf_stalls", 32'(perf_stalls), 32'(saved));

    cyc(BAD, 0, 0);
    cyc(R, 0, 0);
    chk("illegal_ex", 32'(illegal_ex), 1);

    saved = int'(perf_stalls);
    for (int i = 0; i < 5; i++) begin
      cyc(LW, 0, 7);
      cyc(R, 7, 0);
      cyc(R, 7, 0);
    end
    cyc(R, 0, 0);
    chk("perf_stalls +5", 32'(perf_stalls), 32'(saved + 5));
    chk("perf_stalls2 sat", 32'(perf_stalls2), 3);

    // reset in the middle of a stall
    cyc(LW, 0, 4);
    cyc(R, 4, 0, 0, 0);
    cyc(R, 4, 0);
    chk("rst stall ex_ctrl", 32'(ex_ctrl), 0);
    chk("rst stall perf", 32'(perf_stalls), 0);
    chk("rst stall pc_write", 32'(pc_write), 1);
    cyc(R, 0, 0);
    cyc(R, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
